bus_mux16_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 16:1 bus multiplexer among 16 requesters.

---
 rtl/bus_mux16_rr_arbiter_if.sv | 21 ++
 rtl/bus_mux16_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_mux16_rr_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_mux16_rr_arbiter_if.sv
// Handshake bundle between the 16 requesters and the shared-mux arbiter.
// The slave side is the arbiter; the master side drives requests and arbEnable.
interface bus_mux16_rr_arbiter_if;
  logic        arbEnable;
  logic [15:0] req;
  logic [3:0]  sel;
  logic        enable;
  logic [15:0] grant;
  logic        busy;
  logic        preempt;

  modport master (
    output arbEnable, req,
    input  sel, enable, grant, busy, preempt
  );

  modport slave (
    input  arbEnable, req,
    output sel, enable, grant, busy, preempt
  );
endinterface

// File: rtl/bus_mux16_rr_arbiter.sv
// Round-robin owner selection for a 16:1 bus mux. Holds the owner while its request
// stays high, bounded by holdMax when others wait, with one dead cycle per handover.
module bus_mux16_rr_arbiter #(
  parameter int holdMax = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  bus_mux16_rr_arbiter_if.slave        bus
);
  localparam int          NUM_REQ   = 16;
  localparam logic [7:0]  HOLD_LAST = 8'(holdMax - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e               state_q, state_d;
  logic [3:0]           sel_q, sel_d;
  logic                 enable_q, enable_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 preempt_q, preempt_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic [3:0]           last_q, last_d;

  logic [3:0]           win;
  logic                 win_vld;
  logic [3:0]           idx;
  logic                 others;

  // Search starts just after the last owner; the 4-bit add wraps modulo 16.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_q + 4'(k);
      if (!win_vld && bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign others = |(bus.req & ~grant_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    enable_d   = enable_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    case (state_q)
      IDLE, GAP: begin
        if (bus.arbEnable && win_vld) begin
          state_d    = GRANT;
          grant_d    = 16'h0001 << win;
          sel_d      = win;
          enable_d   = 1'b1;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d  = IDLE;
          enable_d = 1'b0;
          grant_d  = '0;
          busy_d   = 1'b0;
        end
      end
      GRANT: begin
        // A falling owner request outranks the timeout, so no preempt on that edge.
        if (!bus.req[sel_q]) begin
          state_d    = GAP;
          last_d     = sel_q;
          grant_d    = '0;
          enable_d   = 1'b0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST && others) begin
          state_d    = GAP;
          last_d     = sel_q;
          grant_d    = '0;
          enable_d   = 1'b0;
          preempt_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
        grant_d  = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      enable_q   <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= 4'd15;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      enable_q   <= enable_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.enable  = enable_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_bus_mux16_rr_arbiter.sv
// Directed and random checks of the round-robin mux arbiter against a behavioural model.
module tb_bus_mux16_rr_arbiter;
  localparam int HM = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bus_mux16_rr_arbiter_if bus();
  bus_mux16_rr_arbiter #(.holdMax(HM)) dut (.clock(clock), .reset(reset), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  // Model: owner index (-1 = nobody), completed grant cycles, last owner, gap flag.
  int m_owner, m_held, m_last, m_sel;
  bit m_gap, m_pre;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 15; m_sel = 0; m_gap = 0; m_pre = 0;
  endtask

  task automatic model_edge(input logic ae, input logic [15:0] rq);
    m_pre = 0;
    if (m_owner >= 0) begin
      if (!rq[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1;
      end else if (m_held + 1 >= HM && (rq & ~(16'h0001 << m_owner)) != 16'h0) begin
        m_last = m_owner; m_owner = -1; m_gap = 1; m_pre = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_gap = 0;
      if (ae && rq != 16'h0) begin
        for (int k = 1; k <= 16; k++) begin
          if (rq[(m_last + k) % 16]) begin
            m_owner = (m_last + k) % 16; m_sel = m_owner; m_held = 0;
            break;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".sel"},     16'(bus.sel),     16'(m_sel));
    chk({tag, ".enable"},  16'(bus.enable),  (m_owner >= 0) ? 16'h1 : 16'h0);
    chk({tag, ".grant"},   bus.grant,        (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0);
    chk({tag, ".busy"},    16'(bus.busy),    (m_owner >= 0 || m_gap) ? 16'h1 : 16'h0);
    chk({tag, ".preempt"}, 16'(bus.preempt), m_pre ? 16'h1 : 16'h0);
  endtask

  task automatic step(input string tag);
    logic ae;
    logic [15:0] rq;
    ae = bus.arbEnable;
    rq = bus.req;
    @(posedge clock);
    model_edge(ae, rq);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    check_model("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n3, np;
    int owners[$];
    int exp_order[4];
    bit prev_en;
    logic [15:0] r;

    reset = 1'b1;
    bus.arbEnable = 1'b1;
    bus.req = 16'h0;
    model_reset();
    #2;
    check_model("init");
    chk("init.busy", 16'(bus.busy), 16'h0);
    #10;
    reset = 1'b0;

    // Test 1: first grant one edge after request
    bus.req = 16'h0001;
    step("t1");
    chk("t1.grant", bus.grant, 16'h0001);
    chk("t1.en", 16'(bus.enable), 16'h1);

    // Test 2: round robin over 0,2,15 with owners dropping after 3 grant cycles
    do_reset();
    exp_order = '{0, 2, 15, 0};
    prev_en = 1'b0;
    for (int i = 0; i < 40 && owners.size() < 4; i++) begin
      bus.req = 16'h8005;
      if (m_owner >= 0 && m_held == 2) bus.req[m_owner] = 1'b0;
      step("t2");
      if (bus.enable && !prev_en) owners.push_back(int'(bus.sel));
      prev_en = bus.enable;
    end
    chk("t2.count", 16'(owners.size()), 16'd4);
    for (int i = 0; i < 4 && i < owners.size(); i++)
      chk("t2.order", 16'(owners[i]), 16'(exp_order[i]));

    // Test 3: hold timeout hands the bus from 3 to 7
    do_reset();
    bus.req = 16'h0008;
    step("t3a");
    n3 = (bus.grant == 16'h0008) ? 1 : 0;
    np = 0;
    bus.req = 16'h0088;
    for (int i = 0; i < 12; i++) begin
      step("t3");
      if (bus.grant == 16'h0008) n3++;
      if (bus.preempt) np++;
      if (bus.grant == 16'h0080) break;
    end
    chk("t3.grant3cycles", 16'(n3), 16'd4);
    chk("t3.preempts", 16'(np), 16'd1);
    chk("t3.grant7", bus.grant, 16'h0080);
    chk("t3.sel7", 16'(bus.sel), 16'd7);

    // Test 4: lone holder never times out
    do_reset();
    bus.req = 16'h0010;
    np = 0; n3 = 0;
    for (int i = 0; i < 50; i++) begin
      step("t4");
      if (bus.preempt) np++;
      if (bus.grant != 16'h0010) n3++;
    end
    chk("t4.preempts", 16'(np), 16'd0);
    chk("t4.lostgrant", 16'(n3), 16'd0);

    // Test 5: arbEnable gating
    do_reset();
    bus.arbEnable = 1'b0;
    bus.req = 16'hFFFF;
    for (int i = 0; i < 5; i++) step("t5a");
    chk("t5.idlebusy", 16'(bus.busy), 16'h0);
    bus.arbEnable = 1'b1;
    step("t5b");
    bus.arbEnable = 1'b0;
    bus.req = 16'h0001;
    for (int i = 0; i < 3; i++) step("t5c");
    chk("t5.keepgrant", bus.grant, 16'h0001);
    bus.req = 16'h0000;
    step("t5d");
    step("t5e");
    chk("t5.backidle", 16'(bus.busy), 16'h0);
    bus.arbEnable = 1'b1;

    // Test 6: async reset mid-grant, then search restarts at 0
    do_reset();
    bus.req = 16'h0200;
    step("t6a");
    chk("t6.sel9", 16'(bus.sel), 16'd9);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6.en", 16'(bus.enable), 16'h0);
    chk("t6.grant", bus.grant, 16'h0);
    chk("t6.busy", 16'(bus.busy), 16'h0);
    chk("t6.sel", 16'(bus.sel), 16'h0);
    #1;
    reset = 1'b0;
    bus.req = 16'h8201;
    step("t6b");
    chk("t6.first", bus.grant, 16'h0001);

    // Random traffic against the model
    do_reset();
    r = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 16'($urandom & $urandom);
      bus.req = r;
      bus.arbEnable = ($urandom_range(0, 9) != 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
